// File: rtl/mem_dbus_ctrl.sv
// mem_dbus_ctrl: MEM-stage data-bus access controller.
// Issues one req/ack transaction per load/store and stalls the pipeline
// while it is outstanding. Load data is returned lane-aligned and extended.
// The transaction holds in HOLD while another block stalls the pipe.
// A flush during WAIT moves to ABORT, which drains the bus and drops the data.
// Optional: `UNALIGNED_EXC_EN enables misaligned-access exceptions
// (adel_o/ades_o/bad_addr_o) and suppresses the bus access.
module mem_dbus_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  output logic        stallreq_o,
  output logic [31:0] load_data_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic [31:0] bad_addr_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [1:0]  state;
  logic        is_ld, is_st, is_sgn, is_mem, mis, go;
  logic [1:0]  sz;
  logic [3:0]  nxt_sel;
  logic [31:0] nxt_wdata;
  logic        ld_q, sgn_q;
  logic [1:0]  sz_q, lane_q;
  logic [31:0] buf_q, ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Decode the EX/MEM operation into load/store, size and signedness.
  always_comb begin
    is_ld  = 1'b0;
    is_st  = 1'b0;
    is_sgn = 1'b0;
    sz     = SZ_W;
    case (aluop_i)
      EXE_LB_OP:  begin is_ld = 1'b1; is_sgn = 1'b1; sz = SZ_B; end
      EXE_LBU_OP: begin is_ld = 1'b1; sz = SZ_B; end
      EXE_LH_OP:  begin is_ld = 1'b1; is_sgn = 1'b1; sz = SZ_H; end
      EXE_LHU_OP: begin is_ld = 1'b1; sz = SZ_H; end
      EXE_LW_OP:  begin is_ld = 1'b1; end
      EXE_SB_OP:  begin is_st = 1'b1; sz = SZ_B; end
      EXE_SH_OP:  begin is_st = 1'b1; sz = SZ_H; end
      EXE_SW_OP:  begin is_st = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem = is_ld | is_st;

`ifdef UNALIGNED_EXC_EN
  assign mis        = is_mem & (((sz == SZ_H) & addr_i[0]) | ((sz == SZ_W) & (addr_i[1:0] != 2'b00)));
  assign adel_o     = ~rst & mis & is_ld;
  assign ades_o     = ~rst & mis & is_st;
  assign bad_addr_o = (~rst & mis) ? addr_i : 32'h0;
`else
  assign mis        = 1'b0;
  assign adel_o     = 1'b0;
  assign ades_o     = 1'b0;
  assign bad_addr_o = 32'h0;
`endif

  // An op that may go on the bus (flush is applied where it matters).
  assign go = is_mem & ~mis;

  // Big-endian byte-lane enables and lane-replicated store data.
  always_comb begin
    nxt_sel   = 4'hF;
    nxt_wdata = reg2_i;
    case (sz)
      SZ_B: begin
        nxt_sel   = 4'b1000 >> addr_i[1:0];
        nxt_wdata = {4{reg2_i[7:0]}};
      end
      SZ_H: begin
        nxt_sel   = addr_i[1] ? 4'b0011 : 4'b1100;
        nxt_wdata = {2{reg2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed lane out of the read word and extend it; stores yield 0.
  always_comb begin
    byte_v = 8'h0;
    half_v = 16'h0;
    ext    = dbus_rdata_i;
    case (sz_q)
      SZ_B: begin
        case (lane_q)
          2'd0:    byte_v = dbus_rdata_i[31:24];
          2'd1:    byte_v = dbus_rdata_i[23:16];
          2'd2:    byte_v = dbus_rdata_i[15:8];
          default: byte_v = dbus_rdata_i[7:0];
        endcase
        ext = {{24{sgn_q & byte_v[7]}}, byte_v};
      end
      SZ_H: begin
        half_v = lane_q[1] ? dbus_rdata_i[15:0] : dbus_rdata_i[31:16];
        ext    = {{16{sgn_q & half_v[15]}}, half_v};
      end
      default: ;
    endcase
    if (!ld_q) ext = 32'h0;
  end

  // Transaction FSM and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= 32'h0;
      dbus_sel_o   <= 4'h0;
      dbus_wdata_o <= 32'h0;
      buf_q        <= 32'h0;
      ld_q         <= 1'b0;
      sgn_q        <= 1'b0;
      sz_q         <= SZ_W;
      lane_q       <= 2'd0;
    end else begin
      case (state)
        S_IDLE: if (go && !flush_i) begin
          state        <= S_WAIT;
          dbus_req_o   <= 1'b1;
          dbus_we_o    <= is_st;
          dbus_addr_o  <= {addr_i[31:2], 2'b00};
          dbus_sel_o   <= nxt_sel;
          dbus_wdata_o <= nxt_wdata;
          ld_q         <= is_ld;
          sgn_q        <= is_sgn;
          sz_q         <= sz;
          lane_q       <= addr_i[1:0];
        end
        S_WAIT: begin
          if (dbus_ack_i) begin
            dbus_req_o <= 1'b0;
            buf_q      <= ext;
            state      <= (flush_i || stall_i == 6'd0) ? S_IDLE : S_HOLD;
          end else if (flush_i) begin
            state <= S_ABORT;
          end
        end
        S_HOLD: if (stall_i == 6'd0 || flush_i) state <= S_IDLE;
        default: if (dbus_ack_i) begin
          dbus_req_o <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  // Stall request and load result to MEM/WB.
  always_comb begin
    stallreq_o  = 1'b0;
    load_data_o = 32'h0;
    if (!rst) begin
      case (state)
        S_IDLE: stallreq_o = go & ~flush_i;
        S_WAIT: begin
          stallreq_o = ~dbus_ack_i;
          if (dbus_ack_i && !flush_i) load_data_o = ext;
        end
        S_HOLD: load_data_o = buf_q;
        default: stallreq_o = go;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// tb_mem_dbus_ctrl: randomized bench for mem_dbus_ctrl with a reference model
// built from lane/size arithmetic and a fixed per-transaction timeline.
module tb_mem_dbus_ctrl;

  localparam logic [7:0] LB = 8'hE0, LBU = 8'hE4, LH = 8'hE1, LHU = 8'hE5;
  localparam logic [7:0] LW = 8'hE3, SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;
  localparam logic [7:0] NOP = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic [7:0]  aluop_i;
  logic [31:0] addr_i, reg2_i, dbus_rdata_i;
  logic        dbus_ack_i;
  logic        dbus_req_o, dbus_we_o, stallreq_o, adel_o, ades_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, load_data_o, bad_addr_o;
  logic [3:0]  dbus_sel_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] ops [10] = '{LB, LBU, LH, LHU, LW, SB, SH, SW, 8'h00, 8'h21};

  mem_dbus_ctrl dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .aluop_i(aluop_i), .addr_i(addr_i), .reg2_i(reg2_i),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o), .stallreq_o(stallreq_o),
    .load_data_o(load_data_o), .adel_o(adel_o), .ades_o(ades_o), .bad_addr_o(bad_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model ----
  function automatic bit m_load(input logic [7:0] op);
    return op == LB || op == LBU || op == LH || op == LHU || op == LW;
  endfunction
  function automatic bit m_store(input logic [7:0] op);
    return op == SB || op == SH || op == SW;
  endfunction
  function automatic int m_size(input logic [7:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction
  function automatic bit m_mis(input logic [7:0] op, input logic [31:0] a);
`ifdef UNALIGNED_EXC_EN
    if (!(m_load(op) || m_store(op))) return 0;
    return (a % m_size(op)) != 0;
`else
    return 0;
`endif
  endfunction
  // Byte n (0 = most significant lane) maps to sel bit 3-n.
  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
    int first, n;
    logic [3:0] s;
    n = m_size(op);
    first = (a % 4) / n * n;
    s = 4'h0;
    for (int i = 0; i < n; i++) s[3 - (first + i)] = 1'b1;
    return s;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] r);
    case (m_size(op))
      1: return (r % 256) * 32'h01010101;
      2: return (r % 65536) * 32'h00010001;
      default: return r;
    endcase
  endfunction
  function automatic logic [31:0] m_ldval(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
    int n, first;
    longint v, span;
    if (!m_load(op)) return 32'h0;
    n = m_size(op);
    first = (a % 4) / n * n;
    span = longint'(1) << (8 * n);
    v = (longint'(rd) >> (8 * (4 - first - n))) % span;
    if ((op == LB || op == LH) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // One complete access: issue at cycle 0, ack at cycle k, then h HOLD cycles.
  task automatic run_txn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                         input logic [31:0] rd, input int k, input int h);
    bit mem, mis;
    logic [31:0] exp_ld;
    mem = m_load(op) || m_store(op);
    mis = m_mis(op, a);
    exp_ld = m_ldval(op, a, rd);
    aluop_i = op; addr_i = a; reg2_i = r2; dbus_ack_i = 1'b0; flush_i = 1'b0; stall_i = 6'd0;
    @(negedge clk);
    chk("issue_stall", stallreq_o, mem && !mis);
    chk("issue_req", dbus_req_o, 0);
    chk("adel", adel_o, mis && m_load(op));
    chk("ades", ades_o, mis && m_store(op));
    chk("bad_addr", bad_addr_o, mis ? a : 32'h0);
    step();
    if (mem && !mis) begin
      for (int c = 1; c <= k; c++) begin
        dbus_ack_i = (c == k);
        dbus_rdata_i = (c == k) ? rd : $urandom;
        stall_i = (c == k) ? ((h > 0) ? 6'b000011 : 6'd0) : 6'($urandom_range(0, 63));
        @(negedge clk);
        chk("wait_req", dbus_req_o, 1);
        chk("wait_we", dbus_we_o, m_store(op));
        chk("wait_addr", dbus_addr_o, a - (a % 4));
        chk("wait_sel", dbus_sel_o, m_sel(op, a));
        chk("wait_wdata", dbus_wdata_o, m_wdata(op, r2));
        chk("wait_stall", stallreq_o, c < k);
        chk("wait_load", load_data_o, (c == k) ? exp_ld : 32'h0);
        step();
      end
      dbus_ack_i = 1'b0;
      dbus_rdata_i = $urandom;
      for (int i = 1; i <= h; i++) begin
        stall_i = (i < h) ? 6'b000011 : 6'd0;
        @(negedge clk);
        chk("hold_load", load_data_o, exp_ld);
        chk("hold_stall", stallreq_o, 0);
        chk("hold_req", dbus_req_o, 0);
        step();
      end
    end
    // Gap cycle; a stray ack here must be ignored.
    aluop_i = NOP; stall_i = 6'd0;
    dbus_ack_i = 1'($urandom_range(0, 1));
    dbus_rdata_i = $urandom;
    @(negedge clk);
    chk("gap_req", dbus_req_o, 0);
    chk("gap_stall", stallreq_o, 0);
    chk("gap_load", load_data_o, 0);
    step();
    dbus_ack_i = 1'b0;
  endtask

  // Flush in WAIT. m = 0: flush and ack together; else ack m cycles after flush.
  task automatic run_abort(input int m, input logic [7:0] op_in_abort);
    aluop_i = LW; addr_i = 32'h40; dbus_ack_i = 1'b0; flush_i = 1'b0; stall_i = 6'd0;
    @(negedge clk);
    chk("ab_issue_stall", stallreq_o, 1);
    step();
    flush_i = 1'b1;
    dbus_ack_i = (m == 0);
    dbus_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("ab_flush_req", dbus_req_o, 1);
    chk("ab_flush_load", load_data_o, 0);
    step();
    flush_i = 1'b0;
    dbus_ack_i = 1'b0;
    aluop_i = op_in_abort;
    for (int j = 1; j <= m; j++) begin
      dbus_ack_i = (j == m);
      @(negedge clk);
      chk("ab_req", dbus_req_o, 1);
      chk("ab_stall", stallreq_o, m_load(op_in_abort) || m_store(op_in_abort));
      chk("ab_load", load_data_o, 0);
      step();
    end
    aluop_i = NOP; dbus_ack_i = 1'b0;
    @(negedge clk);
    chk("ab_done_req", dbus_req_o, 0);
    chk("ab_done_stall", stallreq_o, 0);
    chk("ab_done_load", load_data_o, 0);
    step();
  endtask

  initial begin
    logic [7:0] op;
    rst = 1'b1; stall_i = 6'd0; flush_i = 1'b0; aluop_i = NOP;
    addr_i = 32'h0; reg2_i = 32'h0; dbus_rdata_i = 32'h0; dbus_ack_i = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_req", dbus_req_o, 0);
    chk("rst_we", dbus_we_o, 0);
    chk("rst_addr", dbus_addr_o, 0);
    chk("rst_sel", dbus_sel_o, 0);
    chk("rst_wdata", dbus_wdata_o, 0);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_load", load_data_o, 0);
    chk("rst_adel", adel_o, 0);
    chk("rst_ades", ades_o, 0);
    chk("rst_bad", bad_addr_o, 0);
    step();
    rst = 1'b0;
    step();

    // Directed cases.
    run_txn(LW,  32'h100, 32'h0,        32'h11223344, 3, 0);
    run_txn(LB,  32'h103, 32'h0,        32'h000000F0, 1, 0);
    run_txn(LBU, 32'h103, 32'h0,        32'h000000F0, 1, 0);
    run_txn(SH,  32'h202, 32'hABCD1234, 32'h0,        2, 0);
    run_txn(LH,  32'h0,   32'h0,        32'h80015A5A, 1, 2);
    run_txn(LW,  32'h102, 32'h0,        32'hCAFEF00D, 2, 0);
    run_txn(SW,  32'h301, 32'h12345678, 32'h0,        1, 1);
    run_abort(2, NOP);
    run_abort(0, NOP);
    run_abort(3, LW);

    // Reset while a request is outstanding; the late ack must be ignored.
    aluop_i = LW; addr_i = 32'h80;
    step();
    @(negedge clk);
    chk("rw_req", dbus_req_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0; aluop_i = NOP; dbus_ack_i = 1'b1; dbus_rdata_i = 32'h55555555;
    @(negedge clk);
    chk("rw_req_after", dbus_req_o, 0);
    chk("rw_load_after", load_data_o, 0);
    chk("rw_stall_after", stallreq_o, 0);
    step();
    dbus_ack_i = 1'b0;
    @(negedge clk);
    chk("rw_req_idle", dbus_req_o, 0);
    step();

    // Randomized accesses.
    for (int t = 0; t < 200; t++) begin
      op = ops[$urandom_range(0, 9)];
      run_txn(op, $urandom, $urandom, $urandom, $urandom_range(1, 4), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
